// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared types and helpers for the multiply/divide sequencing controller.
package mdu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } MduOpType;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } MduStateType;

  localparam int unsigned MDU_DIV_STEPS = 32;
  localparam int unsigned MDU_CNT_W     = 5;

  function automatic logic is_mul_op(input MduOpType op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input MduOpType op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle over 32 iterations.
module mdu_div_iter
  import mdu_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam logic [5:0] STEPS = 6'(MDU_DIV_STEPS);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [31:0] step_rem_in, step_quo_in, step_dvs;
  logic [32:0] trial, diff;
  logic [31:0] step_rem, step_quo;

  // The load cycle already performs the first iteration, so results are
  // ready in the 32nd cycle after load without an extra drain cycle.
  always_comb begin
    step_rem_in = load ? '0 : rem_q;
    step_quo_in = load ? dividend : quo_q;
    step_dvs    = load ? divisor : dvs_q;
    trial       = {step_rem_in, step_quo_in[31]};
    diff        = trial - {1'b0, step_dvs};
    if (!diff[32]) begin
      step_rem = diff[31:0];
      step_quo = {step_quo_in[30:0], 1'b1};
    end else begin
      step_rem = trial[31:0];
      step_quo = {step_quo_in[30:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = step_rem;
      quo_d = step_quo;
      dvs_d = divisor;
      cnt_d = 6'd1;
    end else if ((cnt_q != '0) && (cnt_q < STEPS)) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (cnt_q == STEPS);

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: stalls EXE, delivers HI/LO with a one-cycle write pulse.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_Valid,
  input  logic [2:0]  EXE_MduOp,
  input  logic [31:0] EXE_BusA,
  input  logic [31:0] EXE_BusB,
  input  logic        MDU_Flush,
  output logic        MDU_Busy,
  output logic        HILO_Wr,
  output logic [31:0] MDU_HI,
  output logic [31:0] MDU_LO
);

  if ((MUL_LATENCY < 1) || (MUL_LATENCY > 8)) begin : g_bad_mul_latency
    $error("mdu_seq_ctrl: MUL_LATENCY out of range 1..8");
  end
  if (DIV_ITERS != MDU_DIV_STEPS) begin : g_bad_div_iters
    $error("mdu_seq_ctrl: DIV_ITERS must be 32");
  end

  localparam logic [MDU_CNT_W-1:0] MUL_LAST = MDU_CNT_W'(MUL_LATENCY - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LAST = MDU_CNT_W'(DIV_ITERS - 1);

  MduOpType    op_in;
  MduStateType state_q, state_d;
  MduOpType    op_q, op_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_pipe_q [MUL_LATENCY];

  logic        start, start_mul, start_div;
  logic        mul_finish, div_finish;
  logic        in_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_full;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quo, div_rem;
  logic        div_done;
  logic [31:0] q_fix, r_fix;

  assign op_in     = MduOpType'(EXE_MduOp);
  assign start     = (state_q == ST_IDLE) && EXE_Valid && !MDU_Flush &&
                     (is_mul_op(op_in) || is_div_op(op_in));
  assign start_mul = start && is_mul_op(op_in);
  assign start_div = start && is_div_op(op_in);

  assign mul_finish = (state_q == ST_MUL) && !MDU_Flush && (cnt_q == MUL_LAST);
  assign div_finish = (state_q == ST_DIV) && !MDU_Flush && (cnt_q == DIV_LAST) && div_done;

  assign MDU_Busy = start || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign HILO_Wr  = (state_q == ST_DONE) && !MDU_Flush;
  assign MDU_HI   = hi_q;
  assign MDU_LO   = lo_q;

  // Operand conditioning straight from the EXE buses in the start cycle.
  always_comb begin
    in_signed    = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    mul_a        = {in_signed & EXE_BusA[31], EXE_BusA};
    mul_b        = {in_signed & EXE_BusB[31], EXE_BusB};
    mul_full     = 64'(mul_a) * 64'(mul_b);
    div_dividend = in_signed ? abs32(EXE_BusA) : EXE_BusA;
    div_divisor  = in_signed ? abs32(EXE_BusB) : EXE_BusB;
  end

  mdu_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (start_div),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    q_fix = div_quo;
    r_fix = div_rem;
    if ((op_q == MDU_DIV) && (a_q[31] ^ b_q[31])) q_fix = ~div_quo + 32'd1;
    if ((op_q == MDU_DIV) && a_q[31])             r_fix = ~div_rem + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          op_d    = op_in;
          a_d     = EXE_BusA;
          b_d     = EXE_BusB;
          state_d = is_mul_op(op_in) ? ST_MUL : ST_DIV;
        end
      end
      ST_MUL: begin
        if (MDU_Flush || mul_finish) begin
          cnt_d   = '0;
          state_d = MDU_Flush ? ST_IDLE : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (MDU_Flush || div_finish) begin
          cnt_d   = '0;
          state_d = MDU_Flush ? ST_IDLE : ST_DONE;
        end else if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_finish) begin
      {hi_d, lo_d} = prod_pipe_q[MUL_LATENCY-1];
    end else if (div_finish) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = r_fix;
        lo_d = q_fix;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Product is captured at start and shifts one stage per cycle, so the last
  // stage holds it exactly in the final MUL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) prod_pipe_q[i] <= '0;
    end else begin
      if (start_mul) prod_pipe_q[0] <= mul_full;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) prod_pipe_q[i] <= prod_pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed self-checking bench for mdu_seq_ctrl: vector table plus multi-cycle corner sequences.
module tb_mdu_seq_ctrl;
  import mdu_seq_ctrl_pkg::*;

  localparam int unsigned LAT = 3;
  localparam int MUL_D = LAT + 1;
  localparam int DIV_D = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_Valid;
  logic [2:0]  EXE_MduOp;
  logic [31:0] EXE_BusA, EXE_BusB;
  logic        MDU_Flush;
  logic        MDU_Busy, HILO_Wr;
  logic [31:0] MDU_HI, MDU_LO;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_seq_ctrl #(.MUL_LATENCY(LAT), .DIV_ITERS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .EXE_Valid (EXE_Valid),
    .EXE_MduOp (EXE_MduOp),
    .EXE_BusA  (EXE_BusA),
    .EXE_BusB  (EXE_BusB),
    .MDU_Flush (MDU_Flush),
    .MDU_Busy  (MDU_Busy),
    .HILO_Wr   (HILO_Wr),
    .MDU_HI    (MDU_HI),
    .MDU_LO    (MDU_LO)
  );

  typedef struct {
    MduOpType    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input MduOpType op, input logic [31:0] a, input logic [31:0] b);
    EXE_Valid = 1'b1;
    EXE_MduOp = op;
    EXE_BusA  = a;
    EXE_BusB  = b;
  endtask

  task automatic release_inputs();
    EXE_Valid = 1'b0;
    EXE_MduOp = MDU_NONE;
    EXE_BusA  = $urandom();
    EXE_BusB  = $urandom();
  endtask

  // Cycles after the start cycle until HILO_Wr is seen; -1 on timeout.
  task automatic wait_wr(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      release_inputs();
      @(negedge clk);
      if (HILO_Wr) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int d, busy_n, wr_n, wr_k;
    logic [31:0] hi_s, lo_s;
    d = is_mul_op(v.op) ? MUL_D : DIV_D;
    hi_s = '0;
    lo_s = '0;
    @(posedge clk); #1;
    drive_op(v.op, v.a, v.b);
    @(negedge clk);
    busy_n = MDU_Busy ? 1 : 0;
    wr_n   = HILO_Wr ? 1 : 0;
    wr_k   = -1;
    for (int k = 1; k <= d + 1; k++) begin
      @(posedge clk); #1;
      release_inputs();
      @(negedge clk);
      if (MDU_Busy) busy_n++;
      if (HILO_Wr) begin
        wr_n++;
        wr_k = k;
        hi_s = MDU_HI;
        lo_s = MDU_LO;
      end
    end
    chk($sformatf("v%0d busy_cycles", idx), 64'(busy_n), 64'(d));
    chk($sformatf("v%0d wr_cycle", idx), 64'(wr_k), 64'(d));
    chk($sformatf("v%0d wr_pulses", idx), 64'(wr_n), 64'd1);
    chk($sformatf("v%0d hi", idx), {32'd0, hi_s}, {32'd0, v.hi});
    chk($sformatf("v%0d lo", idx), {32'd0, lo_s}, {32'd0, v.lo});
    chk($sformatf("v%0d hold_hi", idx), {32'd0, MDU_HI}, {32'd0, v.hi});
    chk($sformatf("v%0d hold_lo", idx), {32'd0, MDU_LO}, {32'd0, v.lo});
  endtask

  initial begin
    int c, wr_seen, busy_seen;
    logic [31:0] prev_hi, prev_lo;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MDU_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{MDU_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[10] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{MDU_DIV,   32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002};

    rst       = 1'b1;
    EXE_Valid = 1'b0;
    EXE_MduOp = MDU_NONE;
    EXE_BusA  = '0;
    EXE_BusB  = '0;
    MDU_Flush = 1'b0;
    #1;
    chk("reset busy", 64'(MDU_Busy), 64'd0);
    chk("reset wr", 64'(HILO_Wr), 64'd0);
    chk("reset hi", {32'd0, MDU_HI}, 64'd0);
    chk("reset lo", {32'd0, MDU_LO}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Back-to-back: MULT, then DIVU started in the cycle right after DONE.
    @(posedge clk); #1;
    drive_op(MDU_MULT, 32'h00000007, 32'hFFFFFFFD);
    @(negedge clk);
    wait_wr(10, c);
    chk("b2b mul wr_cycle", 64'(c), 64'(MUL_D));
    chk("b2b mul hi", {32'd0, MDU_HI}, 64'hFFFFFFFF);
    chk("b2b mul lo", {32'd0, MDU_LO}, 64'hFFFFFFEB);
    @(posedge clk); #1;
    drive_op(MDU_DIVU, 32'h00000064, 32'h0000000A);
    @(negedge clk);
    chk("b2b second start busy", 64'(MDU_Busy), 64'd1);
    chk("b2b no pulse at start", 64'(HILO_Wr), 64'd0);
    wait_wr(40, c);
    chk("b2b div wr_cycle", 64'(c), 64'(DIV_D));
    chk("b2b div hi", {32'd0, MDU_HI}, 64'h0);
    chk("b2b div lo", {32'd0, MDU_LO}, 64'hA);

    // Flush at T+10 of a DIV; MULTU accepted at T+11.
    @(posedge clk); #1;
    release_inputs();
    prev_hi = 32'h0;
    prev_lo = 32'hA;
    @(posedge clk); #1;
    drive_op(MDU_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    wr_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      release_inputs();
      if (k == 10) MDU_Flush = 1'b1;
      @(negedge clk);
      if (HILO_Wr) wr_seen++;
    end
    @(posedge clk); #1;
    MDU_Flush = 1'b0;
    #1;
    chk("flush busy T+11", 64'(MDU_Busy), 64'd0);
    chk("flush no wr", 64'(wr_seen), 64'd0);
    chk("flush hi held", {32'd0, MDU_HI}, {32'd0, prev_hi});
    chk("flush lo held", {32'd0, MDU_LO}, {32'd0, prev_lo});
    drive_op(MDU_MULTU, 32'h00010000, 32'h00010000);
    @(negedge clk);
    chk("flush restart busy", 64'(MDU_Busy), 64'd1);
    wait_wr(10, c);
    chk("post-flush mul wr_cycle", 64'(c), 64'(MUL_D));
    chk("post-flush mul hi", {32'd0, MDU_HI}, 64'h1);
    chk("post-flush mul lo", {32'd0, MDU_LO}, 64'h0);

    // Flush in the start cycle suppresses the start.
    @(posedge clk); #1;
    drive_op(MDU_DIV, 32'd5, 32'd1);
    MDU_Flush = 1'b1;
    @(negedge clk);
    chk("idle flush busy", 64'(MDU_Busy), 64'd0);
    @(posedge clk); #1;
    release_inputs();
    MDU_Flush = 1'b0;
    @(negedge clk);
    chk("idle flush stays idle", 64'(MDU_Busy), 64'd0);

    // Flush coinciding with DONE kills the write pulse.
    @(posedge clk); #1;
    drive_op(MDU_MULT, 32'd3, 32'd5);
    @(negedge clk);
    wr_seen = 0;
    for (int k = 1; k <= MUL_D; k++) begin
      @(posedge clk); #1;
      release_inputs();
      if (k == MUL_D) MDU_Flush = 1'b1;
      @(negedge clk);
      if (HILO_Wr) wr_seen++;
    end
    chk("done flush no wr", 64'(wr_seen), 64'd0);
    @(posedge clk); #1;
    MDU_Flush = 1'b0;
    @(negedge clk);
    chk("done flush after wr", 64'(HILO_Wr), 64'd0);
    chk("done flush after busy", 64'(MDU_Busy), 64'd0);

    // Async reset in the middle of a DIVU.
    @(posedge clk); #1;
    drive_op(MDU_DIVU, 32'h0000FFFF, 32'h00000003);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      release_inputs();
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midop rst busy", 64'(MDU_Busy), 64'd0);
    chk("midop rst wr", 64'(HILO_Wr), 64'd0);
    chk("midop rst hi", {32'd0, MDU_HI}, 64'd0);
    chk("midop rst lo", {32'd0, MDU_LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_seen   = 0;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (HILO_Wr) wr_seen++;
      if (MDU_Busy) busy_seen++;
    end
    chk("post rst no wr", 64'(wr_seen), 64'd0);
    chk("post rst no busy", 64'(busy_seen), 64'd0);
    chk("post rst lo", {32'd0, MDU_LO}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
